spi_slave_device: RTL and testbench
===================================

Name: spi_slave_device

Overview:
- Oversampled SPI mode-0 slave that sits directly downstream of the SPI master. It consumes the master's sclk/mosi/cs and returns miso.
- It deserialises received bytes into a one-cycle-pulse parallel output. Transmit bytes come from a one-entry valid/ready holding buffer.
- All pin inputs are synchronised into clk_i. Requirement: f(clk_i) >= 8 x f(sclk).

Parameters:
DATA_W, 8, frame width in bits; MSB first.
SYNC_STAGES, 2, flip-flop depth of the input synchronisers (>= 2).
IDLE_MISO, 1'b0, miso_o level while deselected.
DEFAULT_TX, 8'h00, byte shifted out when the tx buffer is empty at load time.

Ports:
clk_i  in  1  system clock
areset_i  in  1  asynchronous, active-high reset
sclk_i  in  1  SPI clock from master; CPOL=0
mosi_i  in  1  serial data from master
cs_i  in  1  chip select, active low
miso_o  out  1  serial data to master
tx_data_i  in  DATA_W  byte to transmit
tx_valid_i  in  1  tx_data_i valid
tx_ready_o  out  1  tx buffer empty; accepts when tx_valid_i && tx_ready_o
rx_data_o  out  DATA_W  last complete received byte
rx_valid_o  out  1  one-cycle pulse when rx_data_o updates
busy_o  out  1  high while selected (state ACTIVE)
tx_underrun_o  out  1  one-cycle pulse when DEFAULT_TX was loaded

Behaviour:
- Reset values (async on areset_i high, all state cleared):
  - miso_o=IDLE_MISO, tx_ready_o=1, rx_data_o=0, rx_valid_o=0, busy_o=0, tx_underrun_o=0.
  - bit counter=0, both shift registers=0, tx buffer empty, state IDLE.
- Synchronisation and edge detection:
  - sclk_i, mosi_i and cs_i each pass through SYNC_STAGES flops.
  - Edge detect compares the synchronised value with a one-cycle-delayed copy.
  - An edge pulse is visible SYNC_STAGES+1 clk_i cycles after the pin edge.
- FSM states: IDLE, ACTIVE.
  - IDLE -> ACTIVE on synchronised cs falling edge.
  - ACTIVE -> IDLE on synchronised cs rising edge.
- On cs falling edge (same cycle):
  - Load the tx shift register from the buffer if full; otherwise load DEFAULT_TX and pulse tx_underrun_o.
  - miso_o takes the loaded MSB the next cycle. bit counter=0.
- ACTIVE, sclk rising edge:
  - rx_shift <= {rx_shift[DATA_W-2:0], mosi_sync}; bit counter increments.
  - When the counter reaches DATA_W: counter wraps to 0, rx_data_o <= completed byte, rx_valid_o=1 for exactly the next cycle.
- ACTIVE, sclk falling edge:
  - If counter != 0: tx_shift shifts left and miso_o drives the new MSB.
  - If counter == 0 (byte boundary): reload tx_shift from buffer/DEFAULT_TX, same rules as cs fall. miso_o drives the new MSB.
  - This supports back-to-back bytes without deasserting cs.
- tx buffer: one entry.
  - Write when tx_valid_i && tx_ready_o; tx_ready_o drops the next cycle.
  - Buffer is freed on load; tx_ready_o rises the cycle after the load.
  - No bypass: a write in the same cycle as a load is not seen by that load (underrun), but is stored for the next byte.
- cs rising edge mid-byte (counter != 0):
  - Partial byte discarded; no rx_valid_o; counter=0.
  - miso_o=IDLE_MISO next cycle.
  - tx buffer contents retained.
- cs rising edge and sclk edge in the same cycle: cs wins; the sclk edge is ignored.
- sclk edges while IDLE are ignored. miso_o is IDLE_MISO whenever IDLE. busy_o == (state == ACTIVE).
- areset_i mid-transfer: immediate return to reset values. The master's partial frame is lost.

Decomposition:
- Package spi_pkg holds:
  - the DATA_W default and the SYNC_STAGES default;
  - the state typedef enum {IDLE, ACTIVE};
  - IDLE_MISO/DEFAULT_TX defaults, shared with the master-side bench.
- Sub-module spi_sync_edge (parameter SYNC_STAGES; ports clk_i, areset_i, d_i, q_o, rise_o, fall_o):
  - instantiated for sclk_i, cs_i and mosi_i;
  - edge outputs are unused for mosi.

Test Plan:
- Single byte: write tx 0xA5; master sends 0x3C with clk_i = 8x sclk -> master reads 0xA5; rx_data_o=0x3C with one rx_valid_o pulse; tx_ready_o back to 1.
- Back-to-back: tx 0x11, then 0x22 written during byte 1; master sends 0xF0,0x0F under one cs -> master reads 0x11,0x22; two rx_valid_o pulses carrying 0xF0 then 0x0F.
- Underrun: buffer empty at cs fall -> master reads 0x00; tx_underrun_o pulses once; rx still correct.
- Abort: cs deasserted after 5 sclk -> no rx_valid_o; miso_o=IDLE_MISO; the next full transfer of 0x81 yields rx_data_o=0x81.
- Reset mid-transfer: areset_i high after bit 3 -> all outputs at reset values within the same cycle; tx buffer empty (tx_ready_o=1).
- Handshake: hold tx_valid_i with 0x55, 0x66 -> only 0x55 accepted until it is loaded; 0x66 accepted the cycle after tx_ready_o rises.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame/synchroniser defaults, idle levels and the slave state type.
// Used by the slave RTL and by the master-side bench.
package spi_pkg;

    localparam int              SPI_DATA_W      = 8;
    localparam int              SPI_SYNC_STAGES = 2;
    localparam logic            SPI_IDLE_MISO   = 1'b0;
    localparam logic [7:0]      SPI_DEFAULT_TX  = 8'h00;

    typedef enum logic {
        IDLE,
        ACTIVE
    } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin, with rise/fall pulses taken
// from the synchronised value and a one-cycle-delayed copy.
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter int   SYNC_STAGES = SPI_SYNC_STAGES,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk_i,
    input  logic areset_i,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // RESET_VAL matches the pin's idle level so leaving reset never fakes an edge.
    always_ff @(posedge clk_i or posedge areset_i) begin
        if (areset_i) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign q_o    = sync_q[SYNC_STAGES-1];
    assign rise_o = q_o & ~prev_q;
    assign fall_o = ~q_o & prev_q;

endmodule

// File: rtl/spi_slave_device.sv
// Oversampled SPI mode-0 slave: synchronised pins, byte deserialiser with a
// one-cycle rx pulse, and a one-entry valid/ready transmit buffer.
module spi_slave_device
    import spi_pkg::*;
#(
    parameter int                DATA_W      = SPI_DATA_W,
    parameter int                SYNC_STAGES = SPI_SYNC_STAGES,
    parameter logic              IDLE_MISO   = SPI_IDLE_MISO,
    parameter logic [DATA_W-1:0] DEFAULT_TX  = DATA_W'(SPI_DEFAULT_TX)
) (
    input  logic              clk_i,
    input  logic              areset_i,
    input  logic              sclk_i,
    input  logic              mosi_i,
    input  logic              cs_i,
    output logic              miso_o,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    output logic              busy_o,
    output logic              tx_underrun_o
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    spi_state_t        state, state_next;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] rx_shift, tx_shift, tx_buf;
    logic              tx_full;

    logic sclk_sync, sclk_rise, sclk_fall;
    logic cs_sync, cs_rise, cs_fall;
    logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk_i(clk_i), .areset_i(areset_i), .d_i(sclk_i),
        .q_o(sclk_sync), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk_i(clk_i), .areset_i(areset_i), .d_i(cs_i),
        .q_o(cs_sync), .rise_o(cs_rise), .fall_o(cs_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk_i(clk_i), .areset_i(areset_i), .d_i(mosi_i),
        .q_o(mosi_sync), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
    );

    // A load happens on select and at every byte boundary that is not also a deselect.
    logic              load_tx;
    logic [DATA_W-1:0] load_val;
    logic [DATA_W-1:0] rx_next;

    assign load_tx  = ((state == IDLE) && cs_fall) ||
                      ((state == ACTIVE) && !cs_rise && sclk_fall && (bit_cnt == '0));
    assign load_val = tx_full ? tx_buf : DEFAULT_TX;
    assign rx_next  = {rx_shift[DATA_W-2:0], mosi_sync};

    always_ff @(posedge clk_i or posedge areset_i) begin
        if (areset_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cs_fall) state_next = ACTIVE;
            ACTIVE:  if (cs_rise) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge areset_i) begin
        if (areset_i) begin
            bit_cnt       <= '0;
            rx_shift      <= '0;
            tx_shift      <= '0;
            tx_buf        <= '0;
            tx_full       <= 1'b0;
            miso_o        <= IDLE_MISO;
            rx_data_o     <= '0;
            rx_valid_o    <= 1'b0;
            tx_underrun_o <= 1'b0;
        end else begin
            rx_valid_o    <= 1'b0;
            tx_underrun_o <= 1'b0;

            // Writes only land while empty and loads only free a full buffer, so they never collide.
            if (tx_valid_i && !tx_full) begin
                tx_buf  <= tx_data_i;
                tx_full <= 1'b1;
            end

            if (load_tx) begin
                tx_shift      <= load_val;
                miso_o        <= load_val[DATA_W-1];
                tx_underrun_o <= !tx_full;
                if (tx_full) tx_full <= 1'b0;
            end

            if (state == IDLE) begin
                if (cs_fall) bit_cnt <= '0;
            end else if (cs_rise) begin
                bit_cnt <= '0;
                miso_o  <= IDLE_MISO;
            end else begin
                if (sclk_rise) begin
                    rx_shift <= rx_next;
                    if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                        bit_cnt    <= '0;
                        rx_data_o  <= rx_next;
                        rx_valid_o <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                if (sclk_fall && (bit_cnt != '0)) begin
                    tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                    miso_o   <= tx_shift[DATA_W-2];
                end
            end
        end
    end

    assign tx_ready_o = !tx_full;
    assign busy_o     = (state == ACTIVE);

endmodule

// File: tb/tb_spi_slave_device.sv
// Scoreboard bench for spi_slave_device: a bit-banged mode-0 master at clk/8,
// a tx feeder honouring valid/ready, and queues of expected rx and miso bytes.
module tb_spi_slave_device;
    import spi_pkg::*;

    localparam int HALF = 4;

    logic       clk_i = 1'b0;
    logic       areset_i, sclk_i, mosi_i, cs_i, tx_valid_i;
    logic [7:0] tx_data_i;
    logic       miso_o, tx_ready_o, rx_valid_o, busy_o, tx_underrun_o;
    logic [7:0] rx_data_o;

    spi_slave_device dut (
        .clk_i(clk_i), .areset_i(areset_i), .sclk_i(sclk_i), .mosi_i(mosi_i),
        .cs_i(cs_i), .miso_o(miso_o), .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i),
        .tx_ready_o(tx_ready_o), .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o),
        .busy_o(busy_o), .tx_underrun_o(tx_underrun_o)
    );

    always #5 clk_i = ~clk_i;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         rx_pulses = 0;
    int         underruns = 0;
    logic [7:0] exp_rx[$];
    logic [7:0] exp_miso[$];
    logic [7:0] tx_q[$];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic checkResetValues(input string pfx);
        checkOutput({pfx, "_miso"},     miso_o,        SPI_IDLE_MISO);
        checkOutput({pfx, "_tx_ready"}, tx_ready_o,    1'b1);
        checkOutput({pfx, "_rx_data"},  rx_data_o,     8'h00);
        checkOutput({pfx, "_rx_valid"}, rx_valid_o,    1'b0);
        checkOutput({pfx, "_busy"},     busy_o,        1'b0);
        checkOutput({pfx, "_underrun"}, tx_underrun_o, 1'b0);
    endtask

    // Outputs are sampled on the falling clock edge, away from the DUT's active edge.
    always @(negedge clk_i) begin
        if (!areset_i) begin
            if (rx_valid_o) begin
                rx_pulses++;
                if (exp_rx.size() == 0) checkOutput("rx_unexpected_valid", rx_valid_o, 1'b0);
                else                    checkOutput("rx_data", rx_data_o, exp_rx.pop_front());
            end
            if (tx_underrun_o) underruns++;
        end
    end

    // Tx feeder: presents the head of tx_q and pops it once valid && ready was seen.
    initial begin
        logic acc;
        forever begin
            @(negedge clk_i);
            acc = tx_valid_i && tx_ready_o;
            @(posedge clk_i);
            if (acc && tx_q.size() > 0) void'(tx_q.pop_front());
            #1;
            if (tx_q.size() > 0) begin
                tx_valid_i = 1'b1;
                tx_data_i  = tx_q[0];
            end else begin
                tx_valid_i = 1'b0;
            end
        end
    end

    // Master: stop_bits==0 runs nbytes full bytes with the last sclk fall coincident
    // with deselect; otherwise stops after stop_bits clocks (abort or reset).
    task automatic applyStimulus(input logic [7:0] b0, input logic [7:0] b1, input int nbytes,
                                 input int stop_bits, input bit by_reset);
        logic [7:0] tx_byte [2];
        logic [7:0] rd;
        int         total, bi, j;
        tx_byte[0] = b0;
        tx_byte[1] = b1;
        rd = '0;
        total = (stop_bits > 0) ? stop_bits : nbytes * 8;
        cs_i   = 1'b0;
        mosi_i = b0[7];
        cycles(8);
        checkOutput("busy_active", busy_o, 1'b1);
        for (int k = 0; k < total; k++) begin
            bi = k / 8;
            j  = 7 - (k % 8);
            mosi_i = tx_byte[bi][j];
            cycles(HALF);
            rd[j]  = miso_o;
            sclk_i = 1'b1;
            if (j == 0) exp_rx.push_back(tx_byte[bi]);
            cycles(HALF);
            if (k == total - 1 && stop_bits == 0) cs_i = 1'b1;
            sclk_i = 1'b0;
            if (j == 0) begin
                if (exp_miso.size() > 0) checkOutput("miso_byte", rd, exp_miso.pop_front());
                else                     checkOutput("miso_queue_empty", exp_miso.size(), 1);
            end
        end
        if (stop_bits > 0) begin
            cycles(HALF);
            if (by_reset) begin
                areset_i = 1'b1;
                #1;
                checkResetValues("midrst");
                cs_i = 1'b1;
                cycles(3);
                areset_i = 1'b0;
            end else begin
                cs_i = 1'b1;
            end
        end
        cycles(8);
        checkOutput("busy_idle", busy_o, 1'b0);
        checkOutput("miso_idle", miso_o, SPI_IDLE_MISO);
    endtask

    initial begin
        areset_i = 1'b1; sclk_i = 1'b0; mosi_i = 1'b0; cs_i = 1'b1;
        tx_valid_i = 1'b0; tx_data_i = 8'h00;
        cycles(3);
        checkResetValues("por");
        areset_i = 1'b0;
        cycles(4);

        // Single byte
        rx_pulses = 0; underruns = 0;
        tx_q.push_back(8'hA5); exp_miso.push_back(8'hA5);
        cycles(4);
        applyStimulus(8'h3C, 8'h00, 1, 0, 1'b0);
        checkOutput("t1_rx_pulses", rx_pulses, 1);
        checkOutput("t1_rx_data", rx_data_o, 8'h3C);
        checkOutput("t1_tx_ready", tx_ready_o, 1'b1);
        checkOutput("t1_underruns", underruns, 0);

        // Back-to-back under one select; 0x22 is written during byte 1
        rx_pulses = 0; underruns = 0;
        tx_q.push_back(8'h11); tx_q.push_back(8'h22);
        exp_miso.push_back(8'h11); exp_miso.push_back(8'h22);
        cycles(4);
        applyStimulus(8'hF0, 8'h0F, 2, 0, 1'b0);
        checkOutput("t2_rx_pulses", rx_pulses, 2);
        checkOutput("t2_rx_data", rx_data_o, 8'h0F);
        checkOutput("t2_underruns", underruns, 0);

        // Underrun
        rx_pulses = 0; underruns = 0;
        exp_miso.push_back(SPI_DEFAULT_TX);
        applyStimulus(8'h5A, 8'h00, 1, 0, 1'b0);
        checkOutput("t3_underruns", underruns, 1);
        checkOutput("t3_rx_pulses", rx_pulses, 1);
        checkOutput("t3_rx_data", rx_data_o, 8'h5A);

        // Abort after 5 clocks, then a clean transfer
        rx_pulses = 0;
        applyStimulus(8'hC3, 8'h00, 1, 5, 1'b0);
        checkOutput("t4_abort_no_rx", rx_pulses, 0);
        checkOutput("t4_abort_rx_data", rx_data_o, 8'h5A);
        exp_miso.push_back(SPI_DEFAULT_TX);
        applyStimulus(8'h81, 8'h00, 1, 0, 1'b0);
        checkOutput("t4_rx_pulses", rx_pulses, 1);
        checkOutput("t4_rx_data", rx_data_o, 8'h81);

        // Handshake: 0x66 waits until 0x55 has been loaded
        underruns = 0;
        tx_q.push_back(8'h55); tx_q.push_back(8'h66);
        cycles(10);
        checkOutput("hs_hold_ready", tx_ready_o, 1'b0);
        exp_miso.push_back(8'h55);
        applyStimulus(8'h12, 8'h00, 1, 0, 1'b0);
        checkOutput("hs_second_held", tx_ready_o, 1'b0);
        exp_miso.push_back(8'h66);
        applyStimulus(8'h34, 8'h00, 1, 0, 1'b0);
        checkOutput("hs_ready_end", tx_ready_o, 1'b1);
        checkOutput("hs_underruns", underruns, 0);

        // Reset after bit 3 with a byte parked in the buffer
        tx_q.push_back(8'h77); tx_q.push_back(8'h88);
        cycles(4);
        applyStimulus(8'hB6, 8'h00, 1, 3, 1'b1);
        checkOutput("rst_tx_ready", tx_ready_o, 1'b1);
        rx_pulses = 0; underruns = 0;
        exp_miso.push_back(SPI_DEFAULT_TX);
        applyStimulus(8'hE7, 8'h00, 1, 0, 1'b0);
        checkOutput("rst_after_underrun", underruns, 1);
        checkOutput("rst_after_rx_data", rx_data_o, 8'hE7);
        checkOutput("rst_after_rx_pulses", rx_pulses, 1);

        cycles(10);
        checkOutput("rx_drain", exp_rx.size(), 0);
        checkOutput("miso_drain", exp_miso.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
